// File: rtl/dds_pkg.sv
// Shared types and constants for the multi-channel DDS waveform scheduler.
package dds_pkg;

  // Wave segment selector; doubles as the upper two RAM address bits
  typedef enum logic [1:0] {
    TRI = 2'd0,
    SIN = 2'd1,
    SQU = 2'd2,
    RSV = 2'd3
  } wave_e;

  // Scheduler control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  localparam int SEG_SIZE = 1024;
  localparam int STEPW    = 4;

endpackage

// File: rtl/dds_phase_acc.sv
// Single-channel phase accumulator confined to one wave segment.
// A load always beats an advance in the same cycle.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int OFFW = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [OFFW-1:0]  load_val,
  input  logic             advance,
  input  logic [STEPW-1:0] step,
  output logic [OFFW-1:0]  phase
);

  // Phase register: load has priority, otherwise step modulo the segment size
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (load) begin
      phase <= load_val;
    end else if (advance) begin
      phase <= phase + {{(OFFW-STEPW){1'b0}}, step};
    end
  end

endmodule

// File: rtl/dds_ch_sched.sv
// Round-robin scheduler sharing one waveform RAM among NCH DDS channels.
// Each RUN cycle serves one slot; read data returns two edges after the
// slot decision and is steered back to its channel by a tag pipeline.
module dds_ch_sched
  import dds_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int ADDR  = 12,
  parameter int WIDTH = 16,
  parameter int OFFW  = ADDR - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [NCH-1:0]         ch_en,
  input  logic [NCH-1:0]         ch_load,
  input  logic [2*NCH-1:0]       ch_wave,
  input  logic [STEPW*NCH-1:0]   ch_step,
  input  logic [OFFW*NCH-1:0]    ch_phase_start,
  output logic                   ram_en,
  output logic [ADDR-1:0]        ram_addr,
  input  logic [WIDTH-1:0]       ram_dout,
  output logic [WIDTH*NCH-1:0]   dout,
  output logic [NCH-1:0]         dout_valid,
  output logic                   busy
);

  localparam int SW = $clog2(NCH);

  sched_state_e    state, state_next;
  logic [SW-1:0]   slot;
  logic [OFFW-1:0] phase [NCH];
  logic [NCH-1:0]  advance;
  wave_e           wave_s;
  logic [OFFW-1:0] phase_s;
  logic            active;
  logic            do_read;

  logic            t1_valid, t2_valid;
  logic            t1_zero, t2_zero;
  logic [SW-1:0]   t1_slot, t2_slot;

  // One accumulator per channel
  for (genvar k = 0; k < NCH; k++) begin : g_acc
    dds_phase_acc #(.OFFW(OFFW)) u_acc (
      .clk      (clk),
      .reset    (reset),
      .load     (ch_load[k]),
      .load_val (ch_phase_start[k*OFFW +: OFFW]),
      .advance  (advance[k]),
      .step     (ch_step[k*STEPW +: STEPW]),
      .phase    (phase[k])
    );
  end

  // Slot decode: a reserved wave still occupies its slot but reads nothing and keeps its phase
  always_comb begin
    wave_s  = wave_e'(ch_wave[2*slot +: 2]);
    phase_s = phase[slot];
    active  = (state == RUN) && run && ch_en[slot];
    do_read = active && (wave_s != RSV);
    advance = '0;
    if (do_read) advance[slot] = 1'b1;
  end

  // Next-state logic; DRAIN always lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = RUN;
      RUN:     if (!run) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Slot counter advances only in RUN so every restart begins at slot 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              slot <= '0;
    else if (state == RUN)   slot <= slot + 1'b1;
    else                     slot <= '0;
  end

  // RAM request register plus first tag stage, aligned with the request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_en   <= 1'b0;
      ram_addr <= '0;
      t1_valid <= 1'b0;
      t1_zero  <= 1'b0;
      t1_slot  <= '0;
    end else begin
      ram_en   <= do_read;
      if (do_read) ram_addr <= ADDR'({wave_s, phase_s});
      t1_valid <= active;
      t1_zero  <= (wave_s == RSV);
      t1_slot  <= slot;
    end
  end

  // Second tag stage, aligned with RAM read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t2_valid <= 1'b0;
      t2_zero  <= 1'b0;
      t2_slot  <= '0;
    end else begin
      t2_valid <= t1_valid;
      t2_zero  <= t1_zero;
      t2_slot  <= t1_slot;
    end
  end

  // Capture returning data into the tagged channel and pulse its valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= '0;
    end else begin
      dout_valid <= '0;
      if (t2_valid) begin
        dout_valid[t2_slot]             <= 1'b1;
        dout[t2_slot*WIDTH +: WIDTH]    <= t2_zero ? '0 : ram_dout;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
